// File: rtl/matmul_pkg.sv
// Shared types, constants and FP27 arithmetic for the sequential matrix-multiply engine.
// FP27 layout: sign | 8-bit exponent (bias 127) | 18-bit fraction; zero/denormal inputs flush, RNE rounding.
package matmul_pkg;

  localparam int unsigned FP_W  = 27;
  localparam int unsigned FP_EW = 8;
  localparam int unsigned FP_MW = 18;
  localparam logic [FP_W-1:0] FP_ZERO = '0;

  typedef enum logic [1:0] {IDLE, RUN, DONE} mm_state_t;

  typedef struct packed {
    logic             sign;
    logic [FP_EW-1:0] exp;
    logic [FP_MW-1:0] man;
  } fp27_t;

  function automatic int unsigned elem_idx(input int unsigned r, input int unsigned c,
                                           input int unsigned n);
    return FP_W * (r * n + c);
  endfunction

  // sig: [21] hidden bit, [20:3] fraction, [2] guard, [1] round, [0] sticky
  function automatic fp27_t fp_round(input logic s, input logic signed [11:0] e,
                                     input logic [21:0] sig);
    logic               inc;
    logic [19:0]        m;
    logic signed [11:0] e2;
    fp27_t              r;
    inc    = sig[2] & (sig[1] | sig[0] | sig[3]);
    m      = {1'b0, sig[21:3]} + 20'(inc);
    e2     = m[19] ? e + 12'sd1 : e;
    r.sign = s;
    r.man  = m[19] ? m[18:1] : m[17:0];
    r.exp  = e2[7:0];
    if (e2 >= 12'sd255) begin
      r.exp = '1;
      r.man = '0;
    end else if (e2 <= 12'sd0) begin
      r.exp = '0;
      r.man = '0;
    end
    return r;
  endfunction

  function automatic logic [5:0] lzc41(input logic [40:0] v);
    logic [5:0] n;
    logic       found;
    n     = 6'd0;
    found = 1'b0;
    for (int i = 40; i >= 0; i--) begin
      if (v[i]) found = 1'b1;
      else if (!found) n = n + 6'd1;
    end
    return n;
  endfunction

  function automatic logic [FP_W-1:0] fp_mul(input logic [FP_W-1:0] a_bits,
                                             input logic [FP_W-1:0] b_bits);
    fp27_t              a, b, z;
    logic [37:0]        p;
    logic signed [11:0] e;
    logic [21:0]        sig;
    a      = a_bits;
    b      = b_bits;
    z      = '0;
    z.sign = a.sign ^ b.sign;
    if (a.exp == '0 || b.exp == '0) return z;
    p = 38'({1'b1, a.man}) * 38'({1'b1, b.man});
    e = $signed({4'b0, a.exp}) + $signed({4'b0, b.exp}) - 12'sd127;
    if (p[37]) begin
      e   = e + 12'sd1;
      sig = {p[37:17], |p[16:0]};
    end else begin
      sig = {p[36:16], |p[15:0]};
    end
    return fp_round(z.sign, e, sig);
  endfunction

  function automatic logic [FP_W-1:0] fp_add(input logic [FP_W-1:0] a_bits,
                                             input logic [FP_W-1:0] b_bits);
    fp27_t              x, y, t, z;
    logic [7:0]         d;
    logic [41:0]        mx, my0, my, sum;
    logic [40:0]        n;
    logic [5:0]         lz;
    logic signed [11:0] e;
    x  = a_bits;
    y  = b_bits;
    z  = '0;
    t  = '0;
    lz = '0;
    if (x.exp == '0 && y.exp == '0) begin
      z.sign = x.sign & y.sign;
      return z;
    end
    if (x.exp == '0) return y;
    if (y.exp == '0) return x;
    if ({y.exp, y.man} > {x.exp, x.man}) begin
      t = x;
      x = y;
      y = t;
    end
    // Align the smaller operand; shifted-out bits are jammed into the LSB as sticky.
    d   = x.exp - y.exp;
    mx  = {2'b01, x.man, 22'd0};
    my0 = {2'b01, y.man, 22'd0};
    if (d >= 8'd41) my = 42'd1;
    else my = (my0 >> d) | 42'(|(my0 & ((42'd1 << d) - 42'd1)));
    sum = (x.sign == y.sign) ? mx + my : mx - my;
    if (sum == '0) return z;
    e = $signed({4'b0, x.exp});
    if (sum[41]) begin
      n = sum[41:1] | 41'(sum[0]);
      e = e + 12'sd1;
    end else begin
      lz = lzc41(sum[40:0]);
      n  = sum[40:0] << lz;
      e  = e - $signed({6'b0, lz});
    end
    return fp_round(x.sign, e, {n[40:22], n[21], n[20], |n[19:0]});
  endfunction

endpackage

// File: rtl/matmul_seq_lane.sv
// One multiply-accumulate lane: acc_out = FpAdd(use_seed ? seed : acc_in, FpMul(a, b)).
// Purely combinational; the accumulator register lives in the parent.
module fp_mac_lane
  import matmul_pkg::*;
#(
  parameter int unsigned W = FP_W
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic [W-1:0] seed,
  input  logic         use_seed,
  input  logic [W-1:0] acc_in,
  output logic [W-1:0] acc_out
);

  logic [W-1:0] w_prod;
  logic [W-1:0] w_addend;

  assign w_prod   = fp_mul(a, b);
  assign w_addend = use_seed ? seed : acc_in;
  assign acc_out  = fp_add(w_addend, w_prod);

endmodule

// File: rtl/matmul_seq.sv
// Sequential N x N FP27 matrix-multiply engine with valid/ready handshakes on both sides.
// N MAC lanes produce one output row every N cycles; acc=1 adds the previous result.
module matmul_seq
  import matmul_pkg::*;
#(
  parameter int unsigned N = 4,
  parameter int unsigned W = FP_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             acc,
  input  logic [W*N*N-1:0] mat_a,
  input  logic [W*N*N-1:0] mat_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [W*N*N-1:0] mat_out
);

  localparam int unsigned   IW   = (N > 2) ? $clog2(N) : 1;
  localparam logic [IW-1:0] LAST = IW'(N - 1);

  mm_state_t     r_state;
  logic          r_in_ready;
  logic          r_out_valid;
  logic          r_acc;
  logic [IW-1:0] r_i;
  logic [IW-1:0] r_k;
  logic [W-1:0]  r_a    [N][N];
  logic [W-1:0]  r_b    [N][N];
  logic [W-1:0]  r_out  [N][N];
  logic [W-1:0]  r_lane [N];

  logic [W-1:0]  w_a    [N][N];
  logic [W-1:0]  w_b    [N][N];
  logic [W-1:0]  w_lane [N];
  logic [W-1:0]  w_seed [N];
  logic          w_k_first;

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign w_k_first = (r_k == '0);

  // Row-major unpacking of the operand buses and packing of the result register.
  for (genvar r = 0; r < N; r++) begin : g_row
    for (genvar c = 0; c < N; c++) begin : g_col
      assign w_a[r][c]                      = mat_a[elem_idx(r, c, N) +: W];
      assign w_b[r][c]                      = mat_b[elem_idx(r, c, N) +: W];
      assign mat_out[elem_idx(r, c, N) +: W] = r_out[r][c];
    end
  end

  for (genvar j = 0; j < N; j++) begin : g_lane
    assign w_seed[j] = r_acc ? r_out[r_i][j] : FP_ZERO;

    fp_mac_lane #(.W(W)) u_lane (
      .a        (r_a[r_i][r_k]),
      .b        (r_b[r_k][j]),
      .seed     (w_seed[j]),
      .use_seed (w_k_first),
      .acc_in   (r_lane[j]),
      .acc_out  (w_lane[j])
    );
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= IDLE;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_acc       <= 1'b0;
      r_i         <= '0;
      r_k         <= '0;
      for (int r = 0; r < int'(N); r++) begin
        r_lane[r] <= '0;
        for (int c = 0; c < int'(N); c++) begin
          r_a[r][c]   <= '0;
          r_b[r][c]   <= '0;
          r_out[r][c] <= '0;
        end
      end
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_a        <= w_a;
            r_b        <= w_b;
            r_acc      <= acc;
            r_i        <= '0;
            r_k        <= '0;
            r_in_ready <= 1'b0;
            r_state    <= RUN;
          end
        end
        RUN: begin
          for (int j = 0; j < int'(N); j++) r_lane[j] <= w_lane[j];
          // Row complete: commit all lanes into the result register.
          if (r_k == LAST) begin
            for (int j = 0; j < int'(N); j++) r_out[r_i][j] <= w_lane[j];
            r_k <= '0;
            if (r_i == LAST) begin
              r_out_valid <= 1'b1;
              r_state     <= DONE;
            end else begin
              r_i <= r_i + IW'(1);
            end
          end else begin
            r_k <= r_k + IW'(1);
          end
        end
        DONE: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= IDLE;
          end
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

endmodule
